hwpe_stream_fifo_drain: RTL and testbench

//  Consumer-end companion of the HWPE-Stream FIFO: sinks the FIFO pop stream and drains exactly
//  a commanded number of beats, then raises a one-cycle done flag. Beats go to a downstream

---
 rtl/hwpe_stream_fifo_drain_pkg.sv | 19 +
 rtl/hwpe_stream_fifo_drain_if.sv | 13 +
 rtl/hwpe_stream_fifo_drain_skid2.sv | 84 ++++++++
 rtl/hwpe_stream_fifo_drain.sv | 114 +++++++++++
 tb/tb_hwpe_stream_fifo_drain.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_fifo_drain_pkg.sv
// Shared types for the FIFO drain block: the reported flags and the drain FSM states.
package hwpe_stream_fifo_drain_pkg;

    // The reported count is fixed at 16 bits regardless of the internal counter width.
    localparam int unsigned FLAGS_CNT_WIDTH = 16;

    typedef struct packed {
        logic                       busy;
        logic                       done;
        logic [FLAGS_CNT_WIDTH-1:0] cnt;
    } flags_drain_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_RUN,
        DRAIN_DONE
    } drain_state_e;

endpackage

// File: rtl/hwpe_stream_fifo_drain_if.sv
// HWPE-Stream handshake bundle: valid/ready with paired data and byte strobes.
interface hwpe_stream_fifo_drain_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_fifo_drain_skid2.sv
// Two-entry registered buffer; the head entry drives the output, data is zero while empty.
module hwpe_stream_fifo_drain_skid2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [STRB_WIDTH-1:0] in_strb_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [STRB_WIDTH-1:0] out_strb_o,
    output logic [1:0]            occupancy_o
);
    localparam int unsigned BeatWidth = DATA_WIDTH + STRB_WIDTH;

    logic [BeatWidth-1:0] head_q, head_d, tail_q, tail_d, in_beat;
    logic [1:0]           occ_q, occ_d;
    logic                 push, pop;

    assign in_beat = {in_data_i, in_strb_i};
    assign push    = in_valid_i;
    assign pop     = out_ready_i & (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = in_beat;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_beat;
                end else if (push) begin
                    tail_d = in_beat;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                // Full: the tail slides into the head as the head leaves.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = in_beat;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid_o              = (occ_q != 2'd0);
    assign {out_data_o, out_strb_o} = out_valid_o ? head_q : '0;
    assign occupancy_o              = occ_q;

endmodule

// File: rtl/hwpe_stream_fifo_drain.sv
// Drains a commanded number of beats from a FIFO pop port, forwarding or discarding them,
// and pulses done once the last beat has left the block.
module hwpe_stream_fifo_drain
    import hwpe_stream_fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [CNT_WIDTH-1:0]        nb_beats_i,
    input  logic                        discard_i,
    output flags_drain_t                flags_o,
    hwpe_stream_fifo_drain_if.sink      pop_i,
    hwpe_stream_fifo_drain_if.source    push_o
);
    drain_state_e         state_q;
    logic [CNT_WIDTH-1:0] remaining_q, cnt_q;
    logic                 discard_q, busy_q, done_q;

    logic                  pop_ready, accept, skid_in_valid, skid_valid;
    logic [1:0]            skid_occ;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [STRB_WIDTH-1:0] skid_strb;

    // Derived from registers only, so downstream ready never reaches the FIFO side.
    assign pop_ready = (state_q == DRAIN_RUN) && (remaining_q != '0) &&
                       (discard_q || (skid_occ != 2'd2));
    assign accept        = pop_i.valid & pop_ready;
    assign skid_in_valid = accept & ~discard_q;
    assign pop_i.ready   = pop_ready;

    hwpe_stream_fifo_drain_skid2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) i_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (skid_in_valid),
        .in_data_i   (pop_i.data),
        .in_strb_i   (pop_i.strb),
        .out_ready_i (push_o.ready),
        .out_valid_o (skid_valid),
        .out_data_o  (skid_data),
        .out_strb_o  (skid_strb),
        .occupancy_o (skid_occ)
    );

    assign push_o.valid = skid_valid;
    assign push_o.data  = skid_data;
    assign push_o.strb  = skid_strb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= DRAIN_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= DRAIN_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                DRAIN_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        remaining_q <= nb_beats_i;
                        discard_q   <= discard_i;
                        cnt_q       <= '0;
                        if (nb_beats_i == '0) begin
                            state_q <= DRAIN_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                DRAIN_RUN: begin
                    if (accept) begin
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        cnt_q       <= cnt_q + CNT_WIDTH'(1);
                    end
                    // Forwarded beats must all have left the skid before done.
                    if ((remaining_q == '0) && (skid_occ == 2'd0)) begin
                        state_q <= DRAIN_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DRAIN_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= DRAIN_IDLE;
                end
                default: state_q <= DRAIN_IDLE;
            endcase
        end
    end

    assign flags_o.busy = busy_q;
    assign flags_o.done = done_q;
    assign flags_o.cnt  = FLAGS_CNT_WIDTH'(cnt_q);

endmodule

// File: tb/tb_hwpe_stream_fifo_drain.sv
// Randomised and directed bench for hwpe_stream_fifo_drain against a queue-based drain model.
module tb_hwpe_stream_fifo_drain;
    import hwpe_stream_fifo_drain_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic          discard_i = 1'b0;
    logic [CW-1:0] nb_beats_i = '0;
    flags_drain_t  flags_o;

    hwpe_stream_fifo_drain_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) pop_if ();
    hwpe_stream_fifo_drain_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) push_if ();

    hwpe_stream_fifo_drain #(
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .nb_beats_i (nb_beats_i),
        .discard_i  (discard_i),
        .flags_o    (flags_o),
        .pop_i      (pop_if),
        .push_o     (push_if)
    );

    always #5 clk_i = ~clk_i;

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_acc = 0;
    int    dut_done = 0;
    logic [15:0] last_done_cnt = '0;
    beat_t src_q[$], sent[$], out_log[$], m_out[$];
    int    acc_cyc[$], emit_cyc[$];
    bit    rdy_val = 1'b1, rdy_rand = 1'b0, gap_en = 1'b0;

    // Model: phase 0 idle, 1 draining, 2 done pulse; m_out holds beats accepted but not emitted.
    int    m_phase = 0, m_rem = 0, m_cnt = 0;
    bit    m_disc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_i) begin : cmp
        beat_t hd;
        bit    exp_ready, m_acc, m_emit, leave;
        if (src_q.size() > 0 && (!gap_en || $urandom_range(3, 0) != 0)) begin
            pop_if.valid = 1'b1;
            pop_if.data  = src_q[0].data;
            pop_if.strb  = src_q[0].strb;
        end else begin
            pop_if.valid = 1'b0;
            pop_if.data  = '0;
            pop_if.strb  = '0;
        end
        push_if.ready = rdy_rand ? ($urandom_range(1, 0) == 1) : rdy_val;
        #1;
        cyc++;
        exp_ready = (m_phase == 1) && (m_rem != 0) && (m_disc || m_out.size() < 2);
        check("busy", flags_o.busy, m_phase == 1);
        check("done", flags_o.done, m_phase == 2);
        check("cnt", flags_o.cnt, m_cnt);
        check("pop_ready", pop_if.ready, exp_ready);
        check("push_valid", push_if.valid, m_out.size() != 0);
        if (m_out.size() != 0) begin
            check("push_beat", {push_if.data, push_if.strb}, m_out[0]);
        end else begin
            check("push_beat_zero", {push_if.data, push_if.strb}, 0);
        end

        if (pop_if.valid && pop_if.ready) begin
            n_acc++;
            acc_cyc.push_back(cyc);
            if (src_q.size() > 0) hd = src_q.pop_front();
        end
        if (push_if.valid && push_if.ready) begin
            out_log.push_back({push_if.data, push_if.strb});
            emit_cyc.push_back(cyc);
        end
        if (flags_o.done) begin
            dut_done++;
            last_done_cnt = flags_o.cnt;
        end

        m_acc  = pop_if.valid && exp_ready;
        m_emit = (m_out.size() != 0) && push_if.ready;
        if (!rst_ni || clear_i) begin
            m_phase = 0; m_rem = 0; m_cnt = 0; m_disc = 1'b0;
            m_out.delete();
        end else if (m_phase == 0) begin
            if (start_i) begin
                m_rem   = int'(nb_beats_i);
                m_cnt   = 0;
                m_disc  = discard_i;
                m_phase = (nb_beats_i == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            leave = (m_rem == 0) && (m_out.size() == 0);
            if (m_emit) hd = m_out.pop_front();
            if (m_acc) begin
                m_rem--;
                m_cnt++;
                if (!m_disc) m_out.push_back({pop_if.data, pop_if.strb});
            end
            if (leave) m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    task automatic load(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = $urandom;
            b.strb = SW'($urandom);
            src_q.push_back(b);
            sent.push_back(b);
        end
    endtask

    task automatic clr_logs();
        sent.delete(); out_log.delete(); acc_cyc.delete(); emit_cyc.delete();
        n_acc = 0;
    endtask

    task automatic do_start(input int nb, input bit disc);
        @(negedge clk_i);
        start_i = 1'b1; nb_beats_i = CW'(nb); discard_i = disc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i = 0;
        while (dut_done == d0 && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("done_within_budget", dut_done != d0, 1);
        @(negedge clk_i);
        #2;
    endtask

    task automatic check_out(input int nb);
        check("out_count", out_log.size(), nb);
        for (int i = 0; i < nb && i < out_log.size(); i++) check("out_beat", out_log[i], sent[i]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, nb, extra;
        bit disc;
        repeat (3) @(negedge clk_i);
        #2;
        check("reset_flags", flags_o, 0);
        check("reset_pop_ready", pop_if.ready, 0);
        check("reset_push_valid", push_if.valid, 0);
        check("reset_push_beat", {push_if.data, push_if.strb}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Forward 4 beats with open downstream.
        clr_logs(); load(4); d0 = dut_done;
        do_start(4, 1'b0);
        wait_done(d0, 50);
        check_out(4);
        check("s1_done_pulses", dut_done - d0, 1);
        check("s1_done_cnt", last_done_cnt, 4);
        for (int i = 1; i < acc_cyc.size(); i++) check("s1_accept_b2b", acc_cyc[i], acc_cyc[0] + i);
        for (int i = 0; i < emit_cyc.size() && i < acc_cyc.size(); i++)
            check("s1_latency", emit_cyc[i], acc_cyc[i] + 1);

        // Drain 3 of 5 beats.
        clr_logs(); load(5); d0 = dut_done;
        do_start(3, 1'b0);
        wait_done(d0, 50);
        check("s2_accepts", n_acc, 3);
        check("s2_fifo_left", src_q.size(), 2);
        check_out(3);
        src_q.delete();

        // Downstream stall for 10 cycles.
        clr_logs(); load(8); d0 = dut_done; rdy_val = 1'b0;
        do_start(8, 1'b0);
        repeat (10) @(negedge clk_i);
        #2;
        check("s3_accepts_stalled", n_acc, 2);
        check("s3_pop_ready_stalled", pop_if.ready, 0);
        rdy_val = 1'b1;
        wait_done(d0, 80);
        check_out(8);
        check("s3_done_cnt", last_done_cnt, 8);

        // Discard mode.
        clr_logs(); load(6); d0 = dut_done;
        do_start(6, 1'b1);
        wait_done(d0, 50);
        check("s4_accepts", n_acc, 6);
        check("s4_no_output", out_log.size(), 0);
        check("s4_done_cnt", last_done_cnt, 6);
        for (int i = 1; i < acc_cyc.size(); i++) check("s4_accept_b2b", acc_cyc[i], acc_cyc[0] + i);

        // Zero-length command, then a start while busy.
        clr_logs(); d0 = dut_done;
        do_start(0, 1'b0);
        #2;
        check("s5_done_next", flags_o.done, 1);
        wait_done(d0, 5);
        check("s5_done_pulses", dut_done - d0, 1);
        check("s5_no_pop", n_acc, 0);
        clr_logs(); load(4); d0 = dut_done;
        do_start(4, 1'b0);
        start_i = 1'b1; nb_beats_i = CW'(1); discard_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(d0, 50);
        check("s5_busy_start_ignored", last_done_cnt, 4);
        check_out(4);

        // Clear with one beat sitting in the skid.
        clr_logs(); load(4); d0 = dut_done; rdy_val = 1'b0;
        do_start(4, 1'b0);
        @(negedge clk_i);
        clear_i = 1'b1;
        #2;
        check("s6_skid_one", push_if.valid, 1);
        @(negedge clk_i);
        clear_i = 1'b0;
        #2;
        check("s6_flags_cleared", flags_o, 0);
        check("s6_pop_ready", pop_if.ready, 0);
        check("s6_push_valid", push_if.valid, 0);
        check("s6_push_beat", {push_if.data, push_if.strb}, 0);
        check("s6_no_done", dut_done, d0);
        rdy_val = 1'b1;
        src_q.delete(); clr_logs(); load(2); d0 = dut_done;
        do_start(2, 1'b0);
        wait_done(d0, 50);
        check_out(2);
        check("s6_done_cnt", last_done_cnt, 2);

        // Random commands, random gaps and downstream backpressure.
        for (int it = 0; it < 25; it++) begin
            clr_logs();
            nb    = int'($urandom_range(10, 1));
            extra = int'($urandom_range(3, 0));
            disc  = ($urandom_range(3, 0) == 0);
            rdy_rand = 1'b1; gap_en = 1'b1;
            load(nb + extra);
            d0 = dut_done;
            do_start(nb, disc);
            wait_done(d0, 400);
            check("rnd_done_cnt", last_done_cnt, nb);
            check("rnd_fifo_left", src_q.size(), extra);
            if (disc) check("rnd_no_output", out_log.size(), 0);
            else check_out(nb);
            src_q.delete();
        end
        rdy_rand = 1'b0; gap_en = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
